// File: rtl/alu_seq_unit.sv
// Sequential integer ALU: single-cycle RV-style ALU ops plus iterative shift-add multiply
// and restoring divide, behind a valid/ready request and result handshake.
module alu_seq_unit #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_OUT} state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_e;

    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    function automatic op_e m_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_MUL;
            3'b001:  return OP_MULH;
            3'b010:  return OP_MULHSU;
            3'b011:  return OP_MULHU;
            3'b100:  return OP_DIV;
            3'b101:  return OP_DIVU;
            3'b110:  return OP_REM;
            default: return OP_REMU;
        endcase
    endfunction

    state_e              r_state;
    logic [SHW-1:0]      r_cnt;
    logic [XLEN-1:0]     r_result;
    logic                r_zero;
    logic                r_err;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opd;
    logic                r_is_mul;
    logic                r_hi;
    logic                r_neg;

    op_e                 w_op;
    logic [SHW-1:0]      w_shamt;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_is_m;
    logic                w_is_d;
    logic                w_iter;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_neg;
    logic                w_hi;
    logic [XLEN-1:0]     w_res1;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fin;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_OUT);
    assign result    = r_result;
    assign zero      = r_zero;
    assign err       = r_err;

    // I-type never decodes as illegal: funct7_0 is ignored and funct7_5 only picks SRAI.
    always_comb begin
        // NOTE: default assignment first so every path drives w_op and no latch is inferred.
        w_op = OP_ILL;
        case (alu_op)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (funct7_0) begin
                    if (EN_M && !funct7_5) w_op = m_op(funct3);
                end else if (funct7_5) begin
                    if (funct3 == 3'b000)      w_op = OP_SUB;
                    else if (funct3 == 3'b101) w_op = OP_SRA;
                end else begin
                    w_op = base_op(funct3);
                end
            end
            default: begin
                if (funct3 == 3'b101 && funct7_5) w_op = OP_SRA;
                else                              w_op = base_op(funct3);
            end
        endcase
    end

    assign w_shamt  = op_b[SHW-1:0];
    assign w_b_zero = (op_b == '0);
    assign w_ovf    = (op_a == MIN_NEG) && (&op_b);
    assign w_is_m   = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_MULHU);
    assign w_is_d   = (w_op == OP_DIV) || (w_op == OP_DIVU) || (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_iter   = w_is_m || (w_is_d && !w_b_zero && !(((w_op == OP_DIV) || (w_op == OP_REM)) && w_ovf));

    // Iterative ops run on magnitudes; the sign is reapplied when the result is captured.
    assign w_a_neg = op_a[XLEN-1] && ((w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM));
    assign w_b_neg = op_b[XLEN-1] && ((w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM));
    assign w_a_mag = w_a_neg ? -op_a : op_a;
    assign w_b_mag = w_b_neg ? -op_b : op_b;
    assign w_neg   = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_hi    = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_MULHU) ||
                     (w_op == OP_REM) || (w_op == OP_REMU);

    always_comb begin
        w_res1 = '0;
        case (w_op)
            OP_ADD:  w_res1 = op_a + op_b;
            OP_SUB:  w_res1 = op_a - op_b;
            OP_SLL:  w_res1 = op_a << w_shamt;
            OP_SLT:  w_res1 = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: w_res1 = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  w_res1 = op_a ^ op_b;
            OP_SRL:  w_res1 = op_a >> w_shamt;
            OP_SRA:  w_res1 = $signed(op_a) >>> w_shamt;
            OP_OR:   w_res1 = op_a | op_b;
            OP_AND:  w_res1 = op_a & op_b;
            OP_DIV:  w_res1 = w_b_zero ? '1 : op_a;
            OP_DIVU: w_res1 = '1;
            OP_REM:  w_res1 = w_b_zero ? op_a : '0;
            OP_REMU: w_res1 = op_a;
            default: w_res1 = '0;
        endcase
    end

    // r_acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opd};

    always_comb begin
        if (r_is_mul)
            w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        else if (w_diff[XLEN])
            w_acc_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    assign w_prod = r_neg ? -w_acc_next : w_acc_next;
    assign w_quo  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    assign w_rem  = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
    assign w_fin  = r_is_mul ? (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0])
                             : (r_hi ? w_rem : w_quo);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_iter) begin
                            r_state <= ST_ITER;
                            r_cnt   <= '0;
                        end else begin
                            r_state  <= ST_OUT;
                            r_result <= w_res1;
                            r_zero   <= (w_res1 == '0);
                            r_err    <= (w_op == OP_ILL);
                        end
                    end
                end
                ST_ITER: begin
                    if (r_cnt == SHW'(XLEN-1)) begin
                        r_state  <= ST_OUT;
                        r_cnt    <= '0;
                        r_result <= w_fin;
                        r_zero   <= (w_fin == '0);
                        r_err    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_valid) begin
            r_acc    <= {{XLEN{1'b0}}, w_a_mag};
            r_opd    <= w_b_mag;
            r_is_mul <= w_is_m;
            r_hi     <= w_hi;
            r_neg    <= w_neg;
        end else if (r_state == ST_ITER) begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter EN_M, default 1, 1 enables the multiply/divide ops, 0 makes them illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 alu_op  input  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode.
REQ-008 funct3  input  3  instruction bits 14:12.
REQ-009 funct7_5  input  1  instruction bit 30 (sub/sra select).
REQ-010 funct7_0  input  1  instruction bit 25 (M-extension select).
REQ-011 op_a, op_b  input  XLEN each  operands.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 result  output  XLEN  operation result.
REQ-015 zero  output  1  result equals 0; valid with out_valid.
REQ-016 err  output  1  illegal decode; valid with out_valid.

Function
REQ-017 Handshake: a request is accepted when in_valid and in_ready are both high; inputs are sampled only in that cycle.
REQ-018 FSM states IDLE, ITER, OUT; in_ready is high only in IDLE.
REQ-019 IDLE: on acceptance of a single-cycle op or illegal op -> OUT; of a MUL*/DIV*/REM* op with nonzero divisor and no signed overflow -> ITER; otherwise stay.
REQ-020 ITER: one step per cycle for exactly XLEN cycles (shift-add multiply, restoring divide), then -> OUT.
REQ-021 OUT: out_valid high, result/zero/err stable; -> IDLE on out_ready; hold indefinitely while out_ready low.
REQ-022 Latency, acceptance edge to out_valid high: 1 cycle for single-cycle ops, XLEN+1 cycles for iterative ops.
REQ-023 alu_op 00 -> ADD, 01 -> SUB, regardless of funct fields.
REQ-024 alu_op 10, funct7_0=0: funct3 000 ADD (funct7_5=0) / SUB (1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (0) / SRA (1); 110 OR; 111 AND.
REQ-025 alu_op 10, funct7_5=1 with funct3 not 000/101 -> illegal.
REQ-026 alu_op 10, funct7_0=1, EN_M=1: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; EN_M=0 -> illegal; funct7_0=1 with funct7_5=1 -> illegal.
REQ-027 alu_op 11: as 10 with funct7_0 ignored; funct7_5 used only for funct3 101 (SRAI); funct3 000 is always ADD.
REQ-028 Shift amount = op_b[log2(XLEN)-1:0]; upper op_b bits ignored.
REQ-029 SLT/SLTU result = {XLEN-1 zeros, compare bit}; signed compare two's complement.
REQ-030 MUL returns low XLEN bits of product; MULH/MULHSU/MULHU high XLEN bits of 2*XLEN-bit product with signed×signed / signed×unsigned / unsigned×unsigned operands.
REQ-031 Divide by zero: quotient all ones, remainder = op_a, completes in 1 cycle (no ITER).
REQ-032 DIV/REM with op_a = most-negative and op_b = -1: quotient = op_a, remainder 0, 1-cycle latency.
REQ-033 Signed div/rem: quotient truncates toward zero; remainder sign follows dividend.
REQ-034 Illegal op: result 0, err 1, zero 1, 1-cycle latency.
REQ-035 ADD/SUB wrap modulo 2^XLEN; no overflow flag.
REQ-036 in_valid high outside IDLE is ignored and not queued.

Reset
REQ-037 rst_n low at a rising edge: state IDLE, out_valid 0, result 0, zero 0, err 0, iteration counter 0, in_ready high on the following cycle.
REQ-038 Reset during ITER or OUT aborts the operation; no result is ever presented for it.

Verification
REQ-039 Reset then ADD, op_a=5, op_b=7, alu_op 00 -> out_valid 1 cycle later, result 12, zero 0, err 0.
REQ-040 R-type SUB op_a=9, op_b=9 -> result 0, zero 1; SRA op_a=0x80000000, op_b=0x24 -> result 0xF8000000 (XLEN=32, shamt 4).
REQ-041 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> out_valid after 33 cycles, result 0xFFFFFFFE; in_ready low throughout.
REQ-042 DIV op_a=-7, op_b=0 -> 1 cycle, result 0xFFFFFFFF; REM -7 by 2 -> result -1 after 33 cycles.
REQ-043 Hold out_ready low 10 cycles in OUT -> result stable, in_ready low; then out_ready high -> IDLE next cycle.
REQ-044 rst_n low at cycle 10 of a DIVU -> out_valid never asserts for it; next ADD completes normally; EN_M=0 build with MUL -> err 1, result 0.
